sys_top: RTL and testbench



---
 rtl/fcs_pkg.sv | 36 +++
 rtl/fcs_crc32_serial.sv | 119 +++++++++++
 rtl/sys_top.sv | 55 +++++
 tb/tb_sys_top.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fcs_pkg.sv
// Shared definitions for the serial CRC-32 frame-check-sequence verifier.
package fcs_pkg;

  // CRC-32 generator polynomial, implicit x^32 term.
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  // Register width and FCS field length in bits.
  localparam int CRC_W   = 32;
  localparam int FCS_LEN = 32;

  // Counter width: holds 0..32 for the saturating data counter.
  localparam int CNT_W = 6;

  // Frame-level control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    FCS  = 2'd2,
    DONE = 2'd3
  } fcs_state_e;

  // One serial step of the checker register: shift the (possibly
  // complemented) bit in at the bottom, fold the polynomial back in when a
  // one falls off the top.
  function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                           input logic        d,
                                           input logic [31:0] poly);
    logic [31:0] nxt;
    nxt = {crc[30:0], d};
    if (crc[31]) begin
      nxt = nxt ^ poly;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fcs_crc32_serial.sv
// Serial CRC-32 frame checker: frame state machine, checker register and
// bit counters. The verdict (register non-zero after the FCS field) is
// staged for one cycle and then published on o_fcs_error.
module fcs_crc32_serial
  import fcs_pkg::*;
#(
  parameter logic [31:0] POLY     = CRC_POLY,
  parameter int          FCS_BITS = FCS_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sof,
  input  logic i_eof,
  input  logic i_data,
  output logic o_fcs_error
);

  localparam logic [CNT_W-1:0] DCNT_SAT = CNT_W'(CRC_W);
  localparam logic [CNT_W-1:0] FCNT_END = CNT_W'(FCS_BITS - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  fcs_state_e       r_state;
  logic [31:0]      r_crc;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_fcnt;
  logic             r_verdict;
  logic             r_verdict_vld;
  logic             r_fcs_error;
  logic             w_data_bit;

  // Reset synchroniser: assertion passes straight through, release is
  // aligned to the clock after two flops.
  // NOTE: sequential state is written with non-blocking (<=) assignments
  // so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // The first 32 payload bits are complemented, equivalent to presetting a
  // direct-form CRC to all ones.
  assign w_data_bit = (r_dcnt < DCNT_SAT) ? ~i_data : i_data;

  // Frame state machine, checker register, counters and registered verdict.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= IDLE;
      r_crc         <= '0;
      r_dcnt        <= '0;
      r_fcnt        <= '0;
      r_verdict     <= 1'b0;
      r_verdict_vld <= 1'b0;
      r_fcs_error   <= 1'b0;
    end else begin
      r_verdict_vld <= 1'b0;

      // Publish a staged verdict one cycle after DONE.
      if (r_verdict_vld) begin
        r_fcs_error <= r_verdict;
      end

      // The verdict of a finished frame is captured even if a new SOF
      // arrives in the same cycle, so back-to-back frames each report.
      if (r_state == DONE) begin
        r_verdict     <= |r_crc;
        r_verdict_vld <= 1'b1;
      end

      if (i_sof) begin
        // Restart from any state; the bit present with SOF is not a frame bit.
        r_state <= DATA;
        r_crc   <= '0;
        r_dcnt  <= '0;
        r_fcnt  <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          DATA: begin
            r_crc <= crc_step(r_crc, w_data_bit, POLY);
            if (r_dcnt != DCNT_SAT) begin
              r_dcnt <= r_dcnt + 1'b1;
            end
            if (i_eof) begin
              r_state <= FCS;
              r_fcnt  <= '0;
            end
          end
          FCS: begin
            // The transmitted FCS is the complement of the running CRC, so
            // re-complementing it drives a clean frame to a zero residue.
            r_crc <= crc_step(r_crc, ~i_data, POLY);
            if (r_fcnt == FCNT_END) begin
              r_state <= DONE;
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_fcs_error = r_fcs_error;

endmodule

// File: rtl/sys_top.sv
// FPGA top level of the serial Ethernet FCS verifier: clock buffering plus
// the checker instance.
// Build option SYS_TOP_IBUFDS_EN: when defined, the clock is taken through a
// differential input buffer and a global buffer; when undefined,
// SYS_CLOCK_P drives the logic directly and SYS_CLOCK_N is unused.
module sys_top
  import fcs_pkg::*;
#(
  parameter logic [31:0] POLY     = CRC_POLY,
  parameter int          FCS_BITS = FCS_LEN
) (
  input  logic SYS_CLOCK_P,
  input  logic SYS_CLOCK_N,
  input  logic RST,
  input  logic START_OF_FRAME_top,
  input  logic END_OF_FRAME_top,
  input  logic DATA_IN_top,
  output logic FCS_ERROR_top
);

  logic w_clk;

`ifdef SYS_TOP_IBUFDS_EN
  logic w_clk_ibuf;

  IBUFDS u_ibufds (
    .I  (SYS_CLOCK_P),
    .IB (SYS_CLOCK_N),
    .O  (w_clk_ibuf)
  );

  BUFG u_bufg (
    .I (w_clk_ibuf),
    .O (w_clk)
  );
`else
  logic w_unused_clk_n;

  assign w_clk          = SYS_CLOCK_P;
  assign w_unused_clk_n = SYS_CLOCK_N;
`endif

  fcs_crc32_serial #(
    .POLY     (POLY),
    .FCS_BITS (FCS_BITS)
  ) u_fcs_crc32_serial (
    .clk         (w_clk),
    .rst_n       (RST),
    .i_sof       (START_OF_FRAME_top),
    .i_eof       (END_OF_FRAME_top),
    .i_data      (DATA_IN_top),
    .o_fcs_error (FCS_ERROR_top)
  );

endmodule

// File: tb/tb_sys_top.sv
// Directed testbench for sys_top. Expected FCS values come from an
// independent direct-form CRC-32 (init all ones, final complement) model,
// anchored by the standard "123456789" check value 0xFC891918.
module tb_sys_top;

  logic clk_p = 1'b0;
  logic clk_n;
  logic rst   = 1'b1;
  logic sof   = 1'b0;
  logic eof   = 1'b0;
  logic din   = 1'b0;
  logic err;

  int checks = 0;
  int errors = 0;

  localparam logic [479:0] PAYLOAD = 480'h0010_A47B_EA80_0012_3456_8000_0800_4500_002E_B3FE_0000_8011_0540_C0A8_002C_C0A8_0004_0400_0400_001A_2DE8_0001_0203_0405_0607_0809_0A0B_0C0D_0E0F_1011;
  localparam logic [479:0] KNOWN   = 480'h31_3233_3435_3637_3839;
  localparam logic [31:0]  KNOWN_FCS = 32'hFC891918;

  logic [31:0] good_fcs;

  always #5 clk_p = ~clk_p;
  assign clk_n = ~clk_p;

  sys_top dut (
    .SYS_CLOCK_P        (clk_p),
    .SYS_CLOCK_N        (clk_n),
    .RST                (rst),
    .START_OF_FRAME_top (sof),
    .END_OF_FRAME_top   (eof),
    .DATA_IN_top        (din),
    .FCS_ERROR_top      (err)
  );

  // Direct-form CRC-32, MSB first, init all ones, result complemented.
  function automatic logic [31:0] model_fcs(input logic [479:0] v, input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[31] ^ v[n-1-i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return ~c;
  endfunction

  // Sends SOF, n payload bits (EOF on the last), then the 32 FCS bits.
  // flip inverts one payload bit; stop_at aborts after that many bits.
  // early is the flag seen two cycles after this frame's SOF cycle.
  task automatic send_frame(input logic [479:0] v, input int n,
                            input logic [31:0] fcs, input int flip,
                            input int stop_at, output logic early);
    early = 1'bx;
    @(negedge clk_p);
    sof = 1'b1; eof = 1'b0; din = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) return;
      @(negedge clk_p);
      if (i == 1) early = err;
      sof = 1'b0;
      din = v[n-1-i] ^ (i == flip);
      eof = (i == n - 1);
    end
    for (int j = 0; j < 32; j++) begin
      @(negedge clk_p);
      eof = 1'b0;
      din = fcs[31-j];
    end
  endtask

  // at1: flag one edge after the last FCS bit edge; at2: two edges after.
  task automatic wait_verdict(output logic at1, output logic at2);
    @(negedge clk_p);
    sof = 1'b0; eof = 1'b0; din = 1'b0;
    @(negedge clk_p);
    at1 = err;
    @(negedge clk_p);
    at2 = err;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #12;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_value: got %b expected 0", err);
    end
    repeat (2) @(negedge clk_p);
    rst = 1'b1;
    repeat (6) @(negedge clk_p);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected 0", err);
    end
  endtask

  task automatic test_good_frame();
    logic e, a1, a2;
    send_frame(PAYLOAD, 480, good_fcs, -1, -1, e);
    wait_verdict(a1, a2);
    checks++;
    if (a2 !== 1'b0) begin
      errors++;
      $display("FAIL good_frame: got %b expected 0", a2);
    end
  endtask

  task automatic test_bad_fcs();
    logic e, a1, a2;
    send_frame(PAYLOAD, 480, 32'hFFFFFFFF, -1, -1, e);
    wait_verdict(a1, a2);
    checks++;
    if (a1 !== 1'b0) begin
      errors++;
      $display("FAIL bad_fcs_latency_early: got %b expected 0", a1);
    end
    checks++;
    if (a2 !== 1'b1) begin
      errors++;
      $display("FAIL bad_fcs_verdict: got %b expected 1", a2);
    end
    repeat (20) @(negedge clk_p);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL bad_fcs_hold: got %b expected 1", err);
    end
  endtask

  task automatic test_known_vector();
    logic e, a1, a2;
    send_frame(KNOWN, 72, KNOWN_FCS, -1, -1, e);
    wait_verdict(a1, a2);
    checks++;
    if (a1 !== 1'b1) begin
      errors++;
      $display("FAIL known_vector_prev_hold: got %b expected 1", a1);
    end
    checks++;
    if (a2 !== 1'b0) begin
      errors++;
      $display("FAIL known_vector_123456789: got %b expected 0", a2);
    end
  endtask

  task automatic test_bit_flip();
    logic e, a1, a2;
    send_frame(PAYLOAD, 480, good_fcs, 300, -1, e);
    wait_verdict(a1, a2);
    checks++;
    if (a2 !== 1'b1) begin
      errors++;
      $display("FAIL bit_flip_300: got %b expected 1", a2);
    end
  endtask

  task automatic test_back_to_back();
    logic e, a1, a2;
    test_good_frame();
    send_frame(PAYLOAD, 480, 32'hFFFFFFFF, -1, -1, e);
    send_frame(PAYLOAD, 480, good_fcs, -1, -1, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_first_verdict: got %b expected 1", e);
    end
    wait_verdict(a1, a2);
    checks++;
    if (a1 !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_hold: got %b expected 1", a1);
    end
    checks++;
    if (a2 !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_second_verdict: got %b expected 0", a2);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic e, a1, a2;
    test_bit_flip();
    send_frame(PAYLOAD, 480, good_fcs, -1, 200, e);
    @(negedge clk_p);
    rst = 1'b0; sof = 1'b0; eof = 1'b0; din = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame_async: got %b expected 0", err);
    end
    repeat (3) @(negedge clk_p);
    rst = 1'b1;
    repeat (60) @(negedge clk_p);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame_no_verdict: got %b expected 0", err);
    end
    send_frame(PAYLOAD, 480, good_fcs, -1, -1, e);
    wait_verdict(a1, a2);
    checks++;
    if (a2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame_next_good: got %b expected 0", a2);
    end
  endtask

  task automatic test_sof_restart();
    logic e, a1, a2;
    test_bit_flip();
    send_frame(PAYLOAD, 480, 32'hFFFFFFFF, -1, 100, e);
    send_frame(PAYLOAD, 480, good_fcs, -1, -1, e);
    wait_verdict(a1, a2);
    checks++;
    if (a2 !== 1'b0) begin
      errors++;
      $display("FAIL sof_restart_good: got %b expected 0", a2);
    end
  endtask

  initial begin
    good_fcs = model_fcs(PAYLOAD, 480);
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_known_vector();
    test_bit_flip();
    test_back_to_back();
    test_reset_mid_frame();
    test_sof_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
